top_modut: RTL and testbench

- Self-contained baseband transmit chain: PRBS7 LFSR data source → rate-1/2 K=3 convolutional encoder → QPSK mapper.
- Emits one signed 8-bit I/Q symbol per clock with a valid strobe for a burst of NUM_BITS data bits plus 2 encoder flush bits.
- Sits at the top of the transmit stack and feeds the DAC/channel model.

---
 rtl/top_modut_pkg.sv | 33 +++
 rtl/top_modut_lfsr7.sv | 32 +++
 rtl/top_modut.sv | 130 +++++++++++++
 tb/tb_top_modut.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/top_modut_pkg.sv
// Shared types and constants for the PRBS7 -> conv-encoder -> QPSK transmit chain.
package top_modut_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int               LFSR_W      = 7;
   localparam logic [LFSR_W-1:0] LFSR_RESET = 7'h01;

   // Rate-1/2, K=3 code; tap vector is {b, s1, s2}
   localparam int               ENC_K  = 3;
   localparam logic [ENC_K-1:0] ENC_G0 = 3'b111;
   localparam logic [ENC_K-1:0] ENC_G1 = 3'b101;

   localparam int AMP_DEFAULT = 90;

   // Parity of the taps selected by a generator polynomial
   function automatic logic enc_bit(input logic [ENC_K-1:0] taps,
                                    input logic [ENC_K-1:0] gen);
      return ^(taps & gen);
   endfunction

   // QPSK: bit 0 -> +amp, bit 1 -> -amp
   function automatic logic signed [7:0] qpsk_map(input logic b,
                                                  input logic signed [7:0] amp);
      return b ? -amp : amp;
   endfunction

endpackage

// File: rtl/top_modut_lfsr7.sv
// PRBS7 Fibonacci LFSR (x^7 + x^6 + 1); MSB is the output bit.
module lfsr7
   import top_modut_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              i_load,
   input  logic              i_en,
   input  logic [LFSR_W-1:0] i_seed,
   output logic              o_bit
);

   logic [LFSR_W-1:0] r_lfsr;
   logic [LFSR_W-1:0] w_seed;

   // An all-zero state would lock up the register, so zero seeds start at 1
   assign w_seed = (i_seed == '0) ? LFSR_RESET : i_seed;

   // Load has priority over shifting; otherwise the register is frozen
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lfsr <= LFSR_RESET;
      end else if (i_load) begin
         r_lfsr <= w_seed;
      end else if (i_en) begin
         r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[LFSR_W-1] ^ r_lfsr[LFSR_W-2]};
      end
   end

   assign o_bit = r_lfsr[LFSR_W-1];

endmodule

// File: rtl/top_modut.sv
// Baseband TX burst: PRBS7 source, K=3 rate-1/2 encoder, QPSK mapper.
// One registered I/Q symbol per clock for NUM_BITS data bits + 2 flush bits.
module top_modut
   import top_modut_pkg::*;
#(
   parameter int NUM_BITS = 256,
   parameter int AMP      = AMP_DEFAULT
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [LFSR_W-1:0]       lfsr_seed,
   input  logic                    lfsr_load,
   output logic signed [7:0]       I_out,
   output logic signed [7:0]       Q_out,
   output logic                    valid_out
);

   localparam int                  CNT_W      = $clog2(NUM_BITS) + 1;
   localparam logic [CNT_W-1:0]    LAST_BIT   = CNT_W'(NUM_BITS - 1);
   localparam logic [CNT_W-1:0]    LAST_FLUSH = CNT_W'(1);
   localparam logic signed [7:0]   AMP_S      = 8'(AMP);

   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_s1, r_s2;
   logic              r_valid;
   logic signed [7:0] r_i, r_q;

   logic              w_consume;    // a bit enters the encoder this cycle
   logic              w_last_flush; // final flush bit of the burst
   logic              w_emit;       // register a symbol at this edge
   logic              w_lfsr_bit;
   logic              w_b;
   logic [ENC_K-1:0]  w_taps;
   logic              w_c0, w_c1;

   lfsr7 u_lfsr (
      .clk    (clk),
      .rst    (reset),
      .i_load (lfsr_load),
      .i_en   (r_state == RUN),
      .i_seed (lfsr_seed),
      .o_bit  (w_lfsr_bit)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next state and per-cycle control; a load restarts from any state
   always_comb begin
      w_next       = r_state;
      w_consume    = 1'b0;
      w_last_flush = 1'b0;
      case (r_state)
         IDLE: ;
         RUN: begin
            w_consume = 1'b1;
            if (r_cnt == LAST_BIT) w_next = FLUSH;
         end
         FLUSH: begin
            w_consume = 1'b1;
            if (r_cnt == LAST_FLUSH) begin
               w_next       = DONE;
               w_last_flush = 1'b1;
            end
         end
         DONE: ;
         default: w_next = IDLE;
      endcase
      if (lfsr_load) w_next = RUN;
   end

   // A load edge consumes no bit, except that the last flush symbol is kept
   // so a back-to-back restart loses nothing from the finishing burst.
   assign w_emit = w_consume && (!lfsr_load || w_last_flush);

   // Bit counter: data bits in RUN, flush bits in FLUSH
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (lfsr_load) begin
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_cnt <= (r_cnt == LAST_BIT) ? '0 : r_cnt + 1'b1;
      end else if (r_state == FLUSH) begin
         r_cnt <= (r_cnt == LAST_FLUSH) ? '0 : r_cnt + 1'b1;
      end
   end

   // Encoder input: PRBS bit in RUN, zeros during flush
   assign w_b    = (r_state == RUN) ? w_lfsr_bit : 1'b0;
   assign w_taps = {w_b, r_s1, r_s2};
   assign w_c0   = enc_bit(w_taps, ENC_G0);
   assign w_c1   = enc_bit(w_taps, ENC_G1);

   // Encoder shift memory, cleared on every burst start
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else if (lfsr_load) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else if (w_consume) begin
         r_s2 <= r_s1;
         r_s1 <= w_b;
      end
   end

   // Registered QPSK output; zeroed whenever no symbol is valid
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_valid <= 1'b0;
         r_i     <= '0;
         r_q     <= '0;
      end else begin
         r_valid <= w_emit;
         r_i     <= w_emit ? qpsk_map(w_c0, AMP_S) : 8'sd0;
         r_q     <= w_emit ? qpsk_map(w_c1, AMP_S) : 8'sd0;
      end
   end

   assign I_out     = r_i;
   assign Q_out     = r_q;
   assign valid_out = r_valid;

endmodule

// File: tb/tb_top_modut.sv
// Directed bench for top_modut with a symbol scoreboard built from a
// reference model of the PRBS7 / K=3 encoder / QPSK chain.
module tb_top_modut;

   localparam int NB  = 256;
   localparam int AMP = 90;

   typedef struct { int i; int q; } sym_t;

   logic              clk = 1'b0;
   logic              reset;
   logic [6:0]        lfsr_seed;
   logic              lfsr_load;
   logic signed [7:0] I_out, Q_out;
   logic              valid_out;

   sym_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   top_modut #(.NUM_BITS(NB), .AMP(AMP)) dut (
      .clk       (clk),
      .reset     (reset),
      .lfsr_seed (lfsr_seed),
      .lfsr_load (lfsr_load),
      .I_out     (I_out),
      .Q_out     (Q_out),
      .valid_out (valid_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: expected symbols of one whole burst from a given seed
   task automatic push_burst(input logic [6:0] seed);
      logic [6:0] l;
      logic s1, s2, b, c0, c1;
      sym_t e;
      l = seed; s1 = 1'b0; s2 = 1'b0;
      for (int k = 0; k < NB + 2; k++) begin
         b  = (k < NB) ? l[6] : 1'b0;
         c0 = b ^ s1 ^ s2;
         c1 = b ^ s2;
         e.i = c0 ? -AMP : AMP;
         e.q = c1 ? -AMP : AMP;
         sb.push_back(e);
         s2 = s1; s1 = b;
         if (k < NB) l = {l[5:0], l[6] ^ l[5]};
      end
   endtask

   task automatic load(input logic [6:0] seed);
      lfsr_seed = seed;
      lfsr_load = 1'b1;
      step();
      lfsr_load = 1'b0;
   endtask

   // Pop and compare n symbols; once valid starts it must not drop
   task automatic drain(input string tag, input int n, input int max_cyc,
                        input bit started_in);
      int   got = 0;
      int   cyc = 0;
      bit   started = started_in;
      sym_t e;
      while (got < n && cyc < max_cyc && sb.size() > 0) begin
         step();
         cyc++;
         if (valid_out === 1'b1) begin
            started = 1'b1;
            e = sb.pop_front();
            chk({tag, " I"}, $signed(I_out), e.i);
            chk({tag, " Q"}, $signed(Q_out), e.q);
            got++;
         end else if (started) begin
            chk({tag, " gap"}, valid_out, 1);
         end
      end
      chk({tag, " count"}, got, n);
   endtask

   // After a burst: no more valid cycles and zeroed outputs
   task automatic tail(input string tag);
      int v = 0;
      repeat (8) begin
         step();
         if (valid_out !== 1'b0) v++;
      end
      chk({tag, " tail valid"}, v, 0);
      chk({tag, " tail I"}, $signed(I_out), 0);
      chk({tag, " tail Q"}, $signed(Q_out), 0);
   endtask

   initial begin
      int   v;
      sym_t e;
      reset = 1'b1; lfsr_load = 1'b0; lfsr_seed = '0;

      // Reset state
      repeat (3) step();
      chk("rst valid", valid_out, 0);
      chk("rst I", $signed(I_out), 0);
      chk("rst Q", $signed(Q_out), 0);
      reset = 1'b0;

      // Idle: no valid pulses without a load
      v = 0;
      repeat (30) begin step(); if (valid_out !== 1'b0) v++; end
      chk("idle valid", v, 0);

      // Seed 1010101: first three symbols against hand-derived constants
      push_burst(7'b1010101);
      load(7'b1010101);
      step(); chk("s55 sym0 I", $signed(I_out), -90); chk("s55 sym0 Q", $signed(Q_out), -90);
      e = sb.pop_front();
      step(); chk("s55 sym1 I", $signed(I_out), -90); chk("s55 sym1 Q", $signed(Q_out),  90);
      e = sb.pop_front();
      step(); chk("s55 sym2 I", $signed(I_out),  90); chk("s55 sym2 Q", $signed(Q_out),  90);
      e = sb.pop_front();
      drain("s55", NB - 1, NB + 10, 1'b1);
      tail("s55");

      // Seed 0 must behave as seed 1
      push_burst(7'h01);
      load(7'h00);
      drain("seed0", NB + 2, NB + 10, 1'b0);
      tail("seed0");

      // Restart mid-burst after 100 data bits
      push_burst(7'h5A);
      load(7'h5A);
      drain("pre", 100, 110, 1'b0);
      sb.delete();
      push_burst(7'h33);
      load(7'h33);
      drain("restart", NB + 2, NB + 10, 1'b0);
      tail("restart");

      // Load on the last flush cycle: final symbol kept, next burst contiguous
      push_burst(7'h11);
      load(7'h11);
      drain("b2b a", NB + 1, NB + 10, 1'b0);
      push_burst(7'h6C);
      load(7'h6C);
      chk("b2b last valid", valid_out, 1);
      e = sb.pop_front();
      chk("b2b last I", $signed(I_out), e.i);
      chk("b2b last Q", $signed(Q_out), e.q);
      drain("b2b b", NB + 2, NB + 10, 1'b1);
      tail("b2b b");

      // Async reset between edges mid-burst
      push_burst(7'h47);
      load(7'h47);
      drain("pre rst", 50, 60, 1'b0);
      #2 reset = 1'b1;
      #1;
      chk("arst valid", valid_out, 0);
      chk("arst I", $signed(I_out), 0);
      chk("arst Q", $signed(Q_out), 0);
      #1 reset = 1'b0;
      sb.delete();
      v = 0;
      repeat (20) begin step(); if (valid_out !== 1'b0) v++; end
      chk("post rst idle", v, 0);
      chk("post rst I", $signed(I_out), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
